// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file slice.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ZERO_REG     = 0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserves set, writes clear, reserve wins a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned NUM_RD   = 4,
  parameter  int unsigned NUM_WR   = 2,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR-1:0]              rsv_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  rsv_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]              rd_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Next busy vector: clears first, then sets so a newer producer dominates.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (wr_en[j]) w_busy_nxt[wr_addr[j]] = 1'b0;
    end
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (rsv_en[j]) w_busy_nxt[rsv_addr[j]] = 1'b1;
    end
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy bit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  // Per-port busy lookup.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      rd_busy[i] = r_busy[rd_addr[i]];
    end
  end

endmodule

// File: rtl/multi_port_register_file.sv
// Multi-port register file with busy scoreboard for the dual-issue core.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
module multi_port_register_file
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned NUM_RD   = 4,
  parameter  int unsigned NUM_WR   = 2,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic [NUM_WR-1:0]              rsv_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  rsv_addr
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_RD-1:0] w_busy_raw;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (w_busy_raw)
  );

  // Storage: ascending port loop so the highest-indexed writer lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(NUM_REGS); r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_en[j] && (wr_addr[j] != ADDR_W'(ZERO_REG))) begin
          r_regs[wr_addr[j]] <= wr_data[j];
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [NUM_RD-1:0] w_byp_hit;

  // Read muxes with write-through forwarding; busy follows the post-edge state on a hit.
  always_comb begin
    rd_data   = '0;
    rd_busy   = '0;
    w_byp_hit = '0;
    if (!reset) begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
        if (rd_addr[i] != ADDR_W'(ZERO_REG)) begin
          rd_data[i] = r_regs[rd_addr[i]];
          rd_busy[i] = w_busy_raw[i];
          for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en[j] && (wr_addr[j] == rd_addr[i])) begin
              rd_data[i]   = wr_data[j];
              w_byp_hit[i] = 1'b1;
            end
          end
          if (w_byp_hit[i]) begin
            rd_busy[i] = 1'b0;
            for (int j = 0; j < int'(NUM_WR); j++) begin
              if (rsv_en[j] && (rsv_addr[j] == rd_addr[i])) rd_busy[i] = 1'b1;
            end
          end
        end
      end
    end
  end
`else
  // Plain read muxes; outputs forced low while reset is held.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    if (!reset) begin
      for (int i = 0; i < int'(NUM_RD); i++) begin
        if (rd_addr[i] != ADDR_W'(ZERO_REG)) begin
          rd_data[i] = r_regs[rd_addr[i]];
          rd_busy[i] = w_busy_raw[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_port_register_file.sv
// Self-checking bench for multi_port_register_file (either REGFILE_BYPASS_EN setting).
module tb_multi_port_register_file;
  import regfile_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [3:0][4:0]       rd_addr;
  logic [3:0][31:0]      rd_data;
  logic [3:0]            rd_busy;
  logic [1:0]            wr_en;
  logic [1:0][4:0]       wr_addr;
  logic [1:0][31:0]      wr_data;
  logic [1:0]            rsv_en;
  logic [1:0][4:0]       rsv_addr;

  int n_checks = 0;
  int n_errors = 0;

  reg_data_t m_regs [32];
  logic      m_busy [32];

  typedef struct {
    logic             rst;
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][31:0] wd;
    logic [1:0]       re;
    logic [1:0][4:0]  ra;
    logic [3:0][4:0]  rd;
    logic [3:0][31:0] exp_d;
    logic [3:0]       exp_b;
  } vec_t;

  multi_port_register_file dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic rst, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic [1:0] re,
                              logic [4:0] ra0, logic [4:0] ra1,
                              logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [4:0] r3,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3,
                              logic [3:0] eb);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re;
    v.wa[0] = wa0; v.wa[1] = wa1; v.wd[0] = wd0; v.wd[1] = wd1;
    v.ra[0] = ra0; v.ra[1] = ra1;
    v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2; v.rd[3] = r3;
    v.exp_d[0] = e0; v.exp_d[1] = e1; v.exp_d[2] = e2; v.exp_d[3] = e3;
    v.exp_b = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference scoreboard update at the clock edge from the inputs held across it.
  task automatic model_edge();
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    end else begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j] != 5'd0) begin
          m_regs[wr_addr[j]] = wr_data[j];
          m_busy[wr_addr[j]] = 1'b0;
        end
      for (int j = 0; j < 2; j++)
        if (rsv_en[j] && rsv_addr[j] != 5'd0) m_busy[rsv_addr[j]] = 1'b1;
    end
  endtask

  // Reference expectation for one read port given current inputs.
  task automatic model_read(input int i, output logic [31:0] d, output logic b);
    logic hit;
    d = '0; b = 1'b0; hit = 1'b0;
    if (!reset && rd_addr[i] != 5'd0) begin
      d = m_regs[rd_addr[i]];
      b = m_busy[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j] == rd_addr[i]) begin d = wr_data[j]; hit = 1'b1; end
      if (hit) begin
        b = 1'b0;
        for (int j = 0; j < 2; j++)
          if (rsv_en[j] && rsv_addr[j] == rd_addr[i]) b = 1'b1;
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = '0; rsv_addr = '0; rd_addr = '0;
  endtask

  vec_t vecs [13];

  initial begin
    logic [31:0] ed, exp_same;
    logic        eb;

    for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    idle_inputs();

    //         rst we     wa0    wd0            wa1    wd1       re     ra0    ra1    rd0..rd3                  exp data                                                  exp busy
    vecs[0]  = mk(1, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0,                         4'b0000);
    vecs[1]  = mk(0, 2'b01, 5'd5, 32'hDEADBEEF,  5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 5'd6, 5'd7, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0,                         4'b0000);
    vecs[2]  = mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    2'b10, 5'd0, 5'd5, 5'd5, 5'd5, 5'd6, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0,           4'b0000);
    vecs[3]  = mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd6, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0,           4'b0011);
    vecs[4]  = mk(1, 2'b01, 5'd6, 32'h1,         5'd0, 32'h0,    2'b01, 5'd6, 5'd0, 5'd5, 5'd6, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0,                         4'b0000);
    vecs[5]  = mk(0, 2'b01, 5'd0, 32'hFFFFFFFF,  5'd0, 32'h0,    2'b01, 5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0,                         4'b0000);
    vecs[6]  = mk(0, 2'b11, 5'd7, 32'h11,        5'd7, 32'h22,   2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, 32'h0,                         4'b0000);
    vecs[7]  = mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    2'b01, 5'd3, 5'd0, 5'd7, 5'd7, 5'd7, 5'd7, 32'h22, 32'h22, 32'h22, 32'h22,                    4'b0000);
    vecs[8]  = mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 5'd3, 5'd3, 5'd7, 5'd0, 32'h0, 32'h0, 32'h22, 32'h0,                       4'b0011);
    vecs[9]  = mk(0, 2'b01, 5'd3, 32'h33,        5'd0, 32'h0,    2'b10, 5'd0, 5'd3, 5'd7, 5'd0, 5'd5, 5'd6, 32'h22, 32'h0, 32'h0, 32'h0,                       4'b0000);
    vecs[10] = mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3, 32'h33, 32'h33, 32'h33, 32'h33,                    4'b1111);
    vecs[11] = mk(0, 2'b10, 5'd0, 32'h0,         5'd3, 32'h44,   2'b00, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd0, 32'h22, 32'h22, 32'h0, 32'h0,                      4'b0000);
    vecs[12] = mk(0, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0,    2'b00, 5'd0, 5'd0, 5'd3, 5'd7, 5'd3, 5'd0, 32'h44, 32'h22, 32'h44, 32'h0,                     4'b0000);

    // Directed table: reset, r0, write conflict and scoreboard sequences.
    for (int k = 0; k < 13; k++) begin
      reset = vecs[k].rst; wr_en = vecs[k].we; wr_addr = vecs[k].wa; wr_data = vecs[k].wd;
      rsv_en = vecs[k].re; rsv_addr = vecs[k].ra; rd_addr = vecs[k].rd;
      #2;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("row%0d_port%0d_data", k, i), rd_data[i], vecs[k].exp_d[i]);
        chk($sformatf("row%0d_port%0d_busy", k, i), 32'(rd_busy[i]), 32'(vecs[k].exp_b[i]));
      end
      tick();
    end

    // Same-cycle write and read of r9.
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h0;
`endif
    idle_inputs();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) rd_addr[i] = 5'd9;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("byp_same_port%0d_data", i), rd_data[i], exp_same);
      chk($sformatf("byp_same_port%0d_busy", i), 32'(rd_busy[i]), 32'h0);
    end
    tick();
    wr_en = '0;
    #2;
    for (int i = 0; i < 4; i++)
      chk($sformatf("byp_next_port%0d_data", i), rd_data[i], 32'hA5A5A5A5);
    tick();

    // Random dual-issue stress on a narrow address range to force collisions.
    for (int c = 0; c < 1000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int j = 0; j < 2; j++) begin
        wr_en[j]    = 1'($urandom_range(0, 1));
        wr_addr[j]  = 5'($urandom_range(0, 7));
        wr_data[j]  = $urandom;
        rsv_en[j]   = 1'($urandom_range(0, 1));
        rsv_addr[j] = 5'($urandom_range(0, 7));
      end
      for (int i = 0; i < 4; i++) rd_addr[i] = 5'($urandom_range(0, 7));
      #2;
      for (int i = 0; i < 4; i++) begin
        model_read(i, ed, eb);
        chk($sformatf("rand%0d_port%0d_data", c, i), rd_data[i], ed);
        chk($sformatf("rand%0d_port%0d_busy", c, i), 32'(rd_busy[i]), 32'(eb));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
